// File: rtl/csr_access_arb.sv
// rtl/csr_access_arb.sv - two-port CSR read / masked-write arbiter and sequencer
// Optional macro CSR_ARB_SKIPWR_EN: skip the write cycle when the masked data already matches.
module csr_access_arb #(
  parameter int NUM_W  = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              p_req,
  input  logic [1:0]        p_op,
  input  logic [NUM_W-1:0]  p_num,
  input  logic [DATA_W-1:0] p_wmask,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_ready,
  output logic              p_resp_valid,
  output logic              p_resp_flushed,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              c_req,
  input  logic [1:0]        c_op,
  input  logic [NUM_W-1:0]  c_num,
  input  logic [DATA_W-1:0] c_wmask,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ready,
  output logic              c_resp_valid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              flush,
  output logic              csr_re,
  output logic [NUM_W-1:0]  csr_num,
  input  logic [DATA_W-1:0] csr_rvalue,
  output logic              csr_we,
  output logic [DATA_W-1:0] csr_wmask,
  output logic [DATA_W-1:0] csr_wvalue,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner_c;
  logic              r_last_c;
  logic              r_flushed;
  logic [1:0]        r_op;
  logic [NUM_W-1:0]  r_num;
  logic [DATA_W-1:0] r_wmask;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_p_rdata;
  logic [DATA_W-1:0] r_c_rdata;
  logic              w_grant_p;
  logic              w_grant_c;
  logic              w_accept;
  logic              w_is_wr;
  logic              w_abort;
  logic              w_skip;

  // Ties go to the port that was not granted last; reset leaves C as last so P wins first.
  assign w_grant_p = resetn && (r_state == S_IDLE) && !flush && p_req && (!c_req || r_last_c);
  assign w_grant_c = resetn && (r_state == S_IDLE) && !flush && c_req && (!p_req || !r_last_c);
  assign w_accept  = w_grant_p || w_grant_c;
  assign w_is_wr   = (r_op == 2'b01) || (r_op == 2'b10);
  assign w_abort   = !r_owner_c && flush;

`ifdef CSR_ARB_SKIPWR_EN
  assign w_skip = ((csr_rvalue & r_wmask) == (r_wdata & r_wmask));
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RD;
      S_RD:    w_next = (w_abort || !w_is_wr || w_skip) ? S_RSP : S_WR;
      S_WR:    w_next = S_RSP;
      S_RSP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    csr_re         = 1'b0;
    csr_we         = 1'b0;
    csr_num        = '0;
    csr_wmask      = '0;
    csr_wvalue     = '0;
    p_resp_valid   = 1'b0;
    c_resp_valid   = 1'b0;
    p_resp_flushed = 1'b0;
    case (r_state)
      S_RD: begin
        csr_re  = 1'b1;
        csr_num = r_num;
      end
      S_WR: if (!w_abort) begin
        csr_we     = 1'b1;
        csr_num    = r_num;
        csr_wmask  = r_wmask;
        csr_wvalue = r_wdata;
      end
      S_RSP: begin
        p_resp_valid   = !r_owner_c;
        c_resp_valid   = r_owner_c;
        p_resp_flushed = !r_owner_c && r_flushed;
      end
      default: ;
    endcase
  end

  assign p_ready = w_grant_p;
  assign c_ready = w_grant_c;
  assign busy    = (r_state != S_IDLE);
  assign p_rdata = r_p_rdata;
  assign c_rdata = r_c_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner_c <= 1'b0;
      r_last_c  <= 1'b1;
      r_flushed <= 1'b0;
      r_op      <= 2'b00;
      r_num     <= '0;
      r_wmask   <= '0;
      r_wdata   <= '0;
      r_p_rdata <= '0;
      r_c_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_owner_c <= w_grant_c;
        r_last_c  <= w_grant_c;
        r_flushed <= 1'b0;
        r_op      <= w_grant_c ? c_op    : p_op;
        r_num     <= w_grant_c ? c_num   : p_num;
        r_wmask   <= w_grant_c ? c_wmask : p_wmask;
        r_wdata   <= w_grant_c ? c_wdata : p_wdata;
      end
      if (r_state == S_RD) begin
        if (r_owner_c) r_c_rdata <= csr_rvalue;
        else           r_p_rdata <= csr_rvalue;
      end
      if (((r_state == S_RD) || (r_state == S_WR)) && w_abort) r_flushed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csr_access_arb.sv
// tb/tb_csr_access_arb.sv - randomized bench for csr_access_arb with a transaction-timeline model
// Honours CSR_ARB_SKIPWR_EN when the design is built with it.
module tb_csr_access_arb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        p_req, c_req, flush;
  logic [1:0]  p_op, c_op;
  logic [13:0] p_num, c_num;
  logic [31:0] p_wmask, p_wdata, c_wmask, c_wdata;
  logic        p_ready, p_resp_valid, p_resp_flushed, c_ready, c_resp_valid;
  logic [31:0] p_rdata, c_rdata;
  logic        csr_re, csr_we, busy;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue, csr_wmask, csr_wvalue;

  int total = 0;
  int bad   = 0;

  // CSR file emulation: 16 entries, aliased on the low number bits.
  logic [31:0] mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;
  assign csr_rvalue = mem[csr_num[3:0]];

  always @(posedge clk) begin
    if (csr_we)
      mem[csr_num[3:0]] <= (mem[csr_num[3:0]] & ~csr_wmask) | (csr_wvalue & csr_wmask);
    else if (pl_en)
      mem[pl_idx] <= pl_val;
  end

  csr_access_arb dut (
    .clk(clk), .resetn(resetn),
    .p_req(p_req), .p_op(p_op), .p_num(p_num), .p_wmask(p_wmask), .p_wdata(p_wdata),
    .p_ready(p_ready), .p_resp_valid(p_resp_valid), .p_resp_flushed(p_resp_flushed), .p_rdata(p_rdata),
    .c_req(c_req), .c_op(c_op), .c_num(c_num), .c_wmask(c_wmask), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_resp_valid(c_resp_valid), .c_rdata(c_rdata),
    .flush(flush), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one transaction in flight, tracked by cycle offset since acceptance.
  bit          m_busy = 1'b0, m_last_c = 1'b1, m_own_c, m_abort, m_skip;
  int          m_k, m_resp_k;
  logic [1:0]  m_op;
  logic [13:0] m_num;
  logic [31:0] m_mask, m_data, m_old;
  logic [31:0] m_prd = '0, m_crd = '0;
  bit          gp, gc, p_acc = 1'b0, c_acc = 1'b0;
  bit          e_re, e_we, e_rsp, m_wr;

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_busy", busy, 0);         chk("rst_re", csr_re, 0);
      chk("rst_we", csr_we, 0);         chk("rst_num", csr_num, 0);
      chk("rst_pready", p_ready, 0);    chk("rst_cready", c_ready, 0);
      chk("rst_presp", p_resp_valid, 0); chk("rst_cresp", c_resp_valid, 0);
      chk("rst_prd", p_rdata, 0);       chk("rst_crd", c_rdata, 0);
      m_busy = 0; m_last_c = 1; m_prd = '0; m_crd = '0; p_acc = 0; c_acc = 0;
    end else if (!m_busy) begin
      gp = !flush && p_req && (!c_req || m_last_c);
      gc = !flush && c_req && (!p_req || !m_last_c);
      chk("idle_pready", p_ready, gp);  chk("idle_cready", c_ready, gc);
      chk("idle_busy", busy, 0);        chk("idle_re", csr_re, 0);
      chk("idle_we", csr_we, 0);        chk("idle_num", csr_num, 0);
      chk("idle_wmask", csr_wmask, 0);  chk("idle_wval", csr_wvalue, 0);
      chk("idle_presp", p_resp_valid, 0); chk("idle_cresp", c_resp_valid, 0);
      chk("idle_pflush", p_resp_flushed, 0);
      chk("idle_prd", p_rdata, m_prd);  chk("idle_crd", c_rdata, m_crd);
      p_acc = gp; c_acc = gc;
      if (gp || gc) begin
        m_busy = 1; m_k = 0; m_own_c = gc; m_last_c = gc; m_abort = 0;
        m_op   = gc ? c_op : p_op;
        m_num  = gc ? c_num : p_num;
        m_mask = gc ? c_wmask : p_wmask;
        m_data = gc ? c_wdata : p_wdata;
        m_old  = mem[m_num[3:0]];
      end
    end else begin
      p_acc = 0; c_acc = 0;
      m_k++;
      m_wr = (m_op == 2'd1) || (m_op == 2'd2);
`ifdef CSR_ARB_SKIPWR_EN
      m_skip = ((m_old & m_mask) == (m_data & m_mask));
`else
      m_skip = 0;
`endif
      e_re = 0; e_we = 0; e_rsp = 0;
      if (m_k == 1) begin
        e_re = 1;
        if (!m_own_c && flush) begin m_abort = 1; m_resp_k = 2; end
        else m_resp_k = (m_wr && !m_skip) ? 3 : 2;
      end else if (m_k < m_resp_k) begin
        if (!m_own_c && flush) m_abort = 1;
        else e_we = 1;
      end else begin
        e_rsp = 1;
      end
      chk("op_pready", p_ready, 0);     chk("op_cready", c_ready, 0);
      chk("op_busy", busy, 1);          chk("op_re", csr_re, e_re);
      chk("op_we", csr_we, e_we);
      chk("op_num", csr_num, (e_re || e_we) ? m_num : 14'd0);
      chk("op_wmask", csr_wmask, e_we ? m_mask : 32'd0);
      chk("op_wval", csr_wvalue, e_we ? m_data : 32'd0);
      chk("op_presp", p_resp_valid, e_rsp && !m_own_c);
      chk("op_cresp", c_resp_valid, e_rsp && m_own_c);
      chk("op_pflush", p_resp_flushed, e_rsp && !m_own_c && m_abort);
      chk("op_prd", p_rdata, m_prd);    chk("op_crd", c_rdata, m_crd);
      if (m_k == 1) begin
        if (m_own_c) m_crd = m_old;
        else         m_prd = m_old;
      end
      if (e_rsp) m_busy = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pl_en = 1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 0;
  endtask

  task automatic set_p(input logic [1:0] op, input logic [13:0] num, input logic [31:0] mk, input logic [31:0] d);
    p_req = 1; p_op = op; p_num = num; p_wmask = mk; p_wdata = d;
  endtask

  task automatic set_c(input logic [1:0] op, input logic [13:0] num, input logic [31:0] mk, input logic [31:0] d);
    c_req = 1; c_op = op; c_num = num; c_wmask = mk; c_wdata = d;
  endtask

  task automatic wait_ready(input string nm, input bit port_c, input int exp_n);
    int n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(negedge clk);
      if (port_c ? c_ready : p_ready) n = i;
    end
    chk(nm, n, exp_n);
  endtask

  initial begin
    resetn = 0; flush = 0; p_req = 0; c_req = 0;
    p_op = 0; p_num = 0; p_wmask = 0; p_wdata = 0;
    c_op = 0; c_num = 0; c_wmask = 0; c_wdata = 0;
    for (int i = 0; i < 16; i++) preload(4'(i), $urandom);
    step(); resetn = 1;

    // P READ of 0x0006
    preload(4'h6, 32'h1C000000);
    set_p(2'd0, 14'h0006, 32'h0, 32'h0);
    @(negedge clk); chk("t1_ready", p_ready, 1);
    step(); p_req = 0;
    @(negedge clk); chk("t1_re", csr_re, 1); chk("t1_num", csr_num, 14'h0006); chk("t1_we", csr_we, 0);
    @(negedge clk); chk("t1_resp", p_resp_valid, 1); chk("t1_rdata", p_rdata, 32'h1C000000);
    chk("t1_flushed", p_resp_flushed, 0);

    // C XCHG of 0x0030
    preload(4'h0, 32'hFFFF0000);
    set_c(2'd2, 14'h0030, 32'h0000FFFF, 32'h1234ABCD);
    @(negedge clk); chk("t2_ready", c_ready, 1);
    step(); c_req = 0;
    @(negedge clk); chk("t2_we_early", csr_we, 0);
    @(negedge clk); chk("t2_we", csr_we, 1); chk("t2_wmask", csr_wmask, 32'h0000FFFF);
    chk("t2_wval", csr_wvalue, 32'h1234ABCD);
    @(negedge clk); chk("t2_resp", c_resp_valid, 1); chk("t2_rdata", c_rdata, 32'hFFFF0000);
    step(); chk("t2_mem", mem[0], 32'hFFFFABCD);

    // Simultaneous requests from reset
    resetn = 0; step(); step(); resetn = 1;
    set_p(2'd0, 14'h0006, 32'h0, 32'h0);
    set_c(2'd0, 14'h0030, 32'h0, 32'h0);
    @(negedge clk); chk("t3_p_first", p_ready, 1); chk("t3_c_wait0", c_ready, 0);
    step(); p_num = 14'h0041;
    wait_ready("t3_c_after_rsp", 1, 3);
    chk("t3_p_loses_tie", p_ready, 0);
    step(); c_req = 0;
    wait_ready("t3_p_after_c", 0, 3);
    step(); p_req = 0;
    repeat (3) @(negedge clk);

    // P WRITE aborted by flush during RD
    preload(4'h1, 32'h11111111);
    set_p(2'd1, 14'h0041, 32'hFFFFFFFF, 32'hDEADBEEF);
    @(negedge clk); chk("t4_ready", p_ready, 1);
    step(); p_req = 0; flush = 1;
    @(negedge clk); chk("t4_re", csr_re, 1); chk("t4_we1", csr_we, 0);
    step(); flush = 0;
    @(negedge clk); chk("t4_we2", csr_we, 0); chk("t4_resp", p_resp_valid, 1);
    chk("t4_flushed", p_resp_flushed, 1); chk("t4_rdata", p_rdata, 32'h11111111);
    step(); chk("t4_mem", mem[1], 32'h11111111);

    // Same with owner C: flush ignored
    set_c(2'd1, 14'h0041, 32'hFFFFFFFF, 32'hDEADBEEF);
    @(negedge clk); chk("t5_ready", c_ready, 1);
    step(); c_req = 0; flush = 1;
    @(negedge clk);
    step(); flush = 0;
    @(negedge clk); chk("t5_we", csr_we, 1); chk("t5_wval", csr_wvalue, 32'hDEADBEEF);
    @(negedge clk); chk("t5_resp", c_resp_valid, 1); chk("t5_rdata", c_rdata, 32'h11111111);
    step(); chk("t5_mem", mem[1], 32'hDEADBEEF);

    // flush held in IDLE blocks the grant
    flush = 1; set_p(2'd0, 14'h0006, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t6_blocked", p_ready, 0);
      step();
    end
    flush = 0;
    @(negedge clk); chk("t6_released", p_ready, 1);
    step(); p_req = 0;
    repeat (2) @(negedge clk);

    // Reset during WR
    step();
    set_p(2'd1, 14'h0041, 32'hFFFFFFFF, 32'hCAFEF00D);
    @(negedge clk); chk("t7_ready", p_ready, 1);
    step(); p_req = 0;
    @(negedge clk);
    @(negedge clk); chk("t7_we_before", csr_we, 1);
    #2 resetn = 0;
    #1 chk("t7_we_drop", csr_we, 0); chk("t7_busy", busy, 0); chk("t7_noresp", p_resp_valid, 0);
    @(negedge clk);
    step(); resetn = 1;
    @(negedge clk); chk("t7_noresp2", p_resp_valid, 0);
    chk("t7_mem", mem[1], 32'hDEADBEEF);

`ifdef CSR_ARB_SKIPWR_EN
    // Equal-data WRITE skips the write cycle
    preload(4'h6, 32'h1C000000);
    set_p(2'd1, 14'h0006, 32'hFFFFFFFF, 32'h1C000000);
    @(negedge clk); chk("t8_ready", p_ready, 1);
    step(); p_req = 0;
    @(negedge clk); chk("t8_we1", csr_we, 0);
    @(negedge clk); chk("t8_we2", csr_we, 0); chk("t8_resp", p_resp_valid, 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step();
      if (p_acc || !p_req) begin
        p_req   = $urandom_range(0, 2) != 0;
        p_op    = 2'($urandom);
        p_num   = 14'($urandom_range(0, 15)) | (14'($urandom_range(0, 1)) << 8);
        p_wmask = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
        p_wdata = ($urandom_range(0, 3) == 0) ? mem[p_num[3:0]] : $urandom;
      end
      if (c_acc || !c_req) begin
        c_req   = $urandom_range(0, 2) != 0;
        c_op    = 2'($urandom);
        c_num   = 14'($urandom_range(0, 15));
        c_wmask = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
        c_wdata = ($urandom_range(0, 3) == 0) ? mem[c_num[3:0]] : $urandom;
      end
      flush = $urandom_range(0, 7) == 0;
    end
    step(); p_req = 0; c_req = 0; flush = 0;
    repeat (6) @(negedge clk);
    chk("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
